// File: rtl/nand_gate_unit.sv
// Pipelined WIDTH-bit logic unit. Every gate function is built from 2-input NAND
// instances, bit-sliced per lane, behind a 2-stage valid/ready pipeline.

module nand2 (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = ~(a & b);
endmodule

// One bit lane: all eight functions are formed from NANDs, and op picks one of them.
module nand_gate_slice (
    input  logic [2:0] op,
    input  logic       a,
    input  logic       b,
    output logic       y
);
    logic na, nb, nab, g_and, g_or, g_nor, x2, x3, g_xor, g_xnor, g_buf;
    logic [7:0] f;

    nand2 u_na   (.a(a),     .b(a),     .y(na));
    nand2 u_nb   (.a(b),     .b(b),     .y(nb));
    nand2 u_nab  (.a(a),     .b(b),     .y(nab));
    nand2 u_and  (.a(nab),   .b(nab),   .y(g_and));
    nand2 u_or   (.a(na),    .b(nb),    .y(g_or));
    nand2 u_nor  (.a(g_or),  .b(g_or),  .y(g_nor));
    nand2 u_x2   (.a(a),     .b(nab),   .y(x2));
    nand2 u_x3   (.a(b),     .b(nab),   .y(x3));
    nand2 u_xor  (.a(x2),    .b(x3),    .y(g_xor));
    nand2 u_xnor (.a(g_xor), .b(g_xor), .y(g_xnor));
    nand2 u_buf  (.a(na),    .b(na),    .y(g_buf));

    assign f = {g_buf, na, g_xnor, g_xor, g_nor, nab, g_or, g_and};
    assign y = f[op];
endmodule

module nand_gate_unit #(
    parameter int WIDTH   = 4,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_op,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [2:0]         out_op,
    output logic [COUNT_W-1:0] op_count,
    input  logic               clr_count
);
    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    logic             s1_valid, s2_valid;
    logic [2:0]       s1_op;
    logic [WIDTH-1:0] s1_a, s1_b, net;
    logic             s2_ready, s1_load, s2_load, pop;

    // in_ready is combinational from out_ready so a full pipe can pop and push together.
    assign s2_ready  = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s2_ready;
    assign s1_load   = in_valid && in_ready;
    assign s2_load   = s1_valid && s2_ready;
    assign pop       = s2_valid && out_ready;
    assign out_valid = s2_valid;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        nand_gate_slice u_slice (.op(s1_op), .a(s1_a[i]), .b(s1_b[i]), .y(net[i]));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (s1_load) begin
            s1_valid <= 1'b1;
            s1_op    <= in_op;
            s1_a     <= in_a;
            s1_b     <= in_b;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    // Output regs are zeroed once consumed so no stale result lingers.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            out_data <= '0;
            out_op   <= '0;
        end else if (s2_load) begin
            s2_valid <= 1'b1;
            out_data <= net;
            out_op   <= s1_op;
        end else if (pop) begin
            s2_valid <= 1'b0;
            out_data <= '0;
            out_op   <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_count)
            op_count <= '0;
        else if (pop && op_count != CNT_MAX)
            op_count <= op_count + 1'b1;
    end
endmodule
